// File: rtl/romulus_pkg.sv
// Shared defaults, FSM encoding and width helper for the tweakey update block.
// Pure declarations: no latency, no flow control.
package romulus_pkg;

    localparam int LANE_W_DEF    = 32;
    localparam int NUM_LANES_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } tky_state_t;

    function automatic int tky_width(input int lane_w, input int num_lanes);
        return lane_w * num_lanes;
    endfunction

endpackage

// File: rtl/tky_lane_reg.sv
// One tweakey lane: shift-in, round update, optional revert (TKY_UPDATE_REVERT_EN); 1-cycle latency.
// No backpressure; a single write-enable so the register can be clock gated.
module tky_lane_reg
    import romulus_pkg::*;
#(
    parameter int LANE_W = LANE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_shift_en,
    input  logic [LANE_W-1:0] i_shift_dat,
    input  logic              i_upd_en,
    input  logic [LANE_W-1:0] i_upd_dat,
    input  logic              i_rev_en,
    input  logic [LANE_W-1:0] i_rev_dat,
    output logic [LANE_W-1:0] o_lane
);

    logic              w_we;
    logic [LANE_W-1:0] w_nxt;
    logic [LANE_W-1:0] r_lane;

    // Shift and update/revert are mutually exclusive by FSM state, so
    // ordering here only needs to express revert-over-update.
`ifdef TKY_UPDATE_REVERT_EN
    assign w_we = i_shift_en | i_upd_en | i_rev_en;

    always_comb begin
        w_nxt = i_upd_dat;
        if (i_shift_en) begin
            w_nxt = i_shift_dat;
        end else if (i_rev_en) begin
            w_nxt = i_rev_dat;
        end
    end
`else
    logic w_unused_rev;
    assign w_unused_rev = ^{i_rev_en, i_rev_dat};
    assign w_we         = i_shift_en | i_upd_en;
    assign w_nxt        = i_shift_en ? i_shift_dat : i_upd_dat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
        end else if (w_we) begin
            r_lane <= w_nxt;
        end
    end

    assign o_lane = r_lane;

endmodule

// File: rtl/tky_update_param.sv
// Tweakey state: NUM_LANES-word shift load from pdi, else per-round update/revert (TKY_UPDATE_REVERT_EN).
// tky changes 1 cycle after the causing edge; pdi_ready only in LOAD, pdi_valid low stalls the load.
module tky_update_param
    import romulus_pkg::*;
#(
    parameter int  LANE_W    = LANE_W_DEF,
    parameter int  NUM_LANES = NUM_LANES_DEF,
    localparam int TKY_W     = tky_width(LANE_W, NUM_LANES),
    localparam int CNT_W     = $clog2(NUM_LANES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LANE_W-1:0] pdi,
    input  logic             pdi_valid,
    output logic             pdi_ready,
    input  logic             ld_start,
    input  logic             enc,
    input  logic             revert,
    input  logic [TKY_W-1:0] skinny_tky,
    input  logic [TKY_W-1:0] skinny_tky_revert,
    output logic [TKY_W-1:0] tky,
    output logic             ld_done,
    output logic             busy
);

    tky_state_t        r_state;
    tky_state_t        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_ld_done;
    logic              w_idle;
    logic              w_accept;
    logic              w_last;
    logic              w_upd_en;
    logic              w_rev_en;
    logic [LANE_W-1:0] w_lane     [NUM_LANES];
    logic [LANE_W-1:0] w_shift_in [NUM_LANES];

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = (r_state == ST_LOAD) && pdi_valid;
    assign w_last   = (r_cnt == CNT_W'(NUM_LANES - 1));
    assign w_upd_en = w_idle && enc;
    assign w_rev_en = w_idle && revert;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (ld_start)           w_state_nxt = ST_LOAD;
            ST_LOAD: if (w_accept && w_last) w_state_nxt = ST_IDLE;
            default:                         w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter restarts only on IDLE->LOAD, so a repeated ld_start mid-load is harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_ld_done <= 1'b0;
        end else begin
            r_ld_done <= w_accept && w_last;
            if (w_idle && ld_start) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        if (g == 0) begin : g_head
            assign w_shift_in[g] = pdi;
        end else begin : g_body
            assign w_shift_in[g] = w_lane[g-1];
        end

        tky_lane_reg #(
            .LANE_W (LANE_W)
        ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_shift_en  (w_accept),
            .i_shift_dat (w_shift_in[g]),
            .i_upd_en    (w_upd_en),
            .i_upd_dat   (skinny_tky[g*LANE_W +: LANE_W]),
            .i_rev_en    (w_rev_en),
            .i_rev_dat   (skinny_tky_revert[g*LANE_W +: LANE_W]),
            .o_lane      (w_lane[g])
        );

        assign tky[g*LANE_W +: LANE_W] = w_lane[g];
    end

    assign pdi_ready = (r_state == ST_LOAD);
    assign busy      = (r_state == ST_LOAD);
    assign ld_done   = r_ld_done;

endmodule

// File: tb/tb_tky_update_param.sv
// Bench for tky_update_param: 32x4 instance (loads, stalls, updates, reset abort) and 16x8 instance.
module tb_tky_update_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_rst, a_pdi_valid, a_ld_start, a_enc, a_revert;
    logic [31:0]  a_pdi;
    logic [127:0] a_sk, a_skr;
    wire  [127:0] a_tky;
    wire          a_pdi_ready, a_ld_done, a_busy;

    logic         b_rst, b_pdi_valid, b_ld_start, b_enc, b_revert;
    logic [15:0]  b_pdi;
    logic [127:0] b_sk, b_skr;
    wire  [127:0] b_tky;
    wire          b_pdi_ready, b_ld_done, b_busy;

    tky_update_param #(.LANE_W(32), .NUM_LANES(4)) dut_a (
        .clk(clk), .rst(a_rst), .pdi(a_pdi), .pdi_valid(a_pdi_valid), .pdi_ready(a_pdi_ready),
        .ld_start(a_ld_start), .enc(a_enc), .revert(a_revert), .skinny_tky(a_sk),
        .skinny_tky_revert(a_skr), .tky(a_tky), .ld_done(a_ld_done), .busy(a_busy)
    );

    tky_update_param #(.LANE_W(16), .NUM_LANES(8)) dut_b (
        .clk(clk), .rst(b_rst), .pdi(b_pdi), .pdi_valid(b_pdi_valid), .pdi_ready(b_pdi_ready),
        .ld_start(b_ld_start), .enc(b_enc), .revert(b_revert), .skinny_tky(b_sk),
        .skinny_tky_revert(b_skr), .tky(b_tky), .ld_done(b_ld_done), .busy(b_busy)
    );

`ifdef TKY_UPDATE_REVERT_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    typedef struct {
        string        name;
        logic         enc;
        logic         rev;
        logic [127:0] sk;
        logic [127:0] skr;
        logic [127:0] exp;
    } vec_t;

    int           n_chk = 0;
    int           n_fail = 0;
    logic [127:0] sb_q[$];
    logic [127:0] m_tky;
    int           a_tcount, a_done_at, a_done_cnt;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every A-side cycle goes through here so each ld_done pulse is matched
    // against the scoreboard entry pushed when its final word was driven.
    task automatic a_tick();
        logic [127:0] e;
        tick();
        a_tcount++;
        if (a_ld_done === 1'b1) begin
            a_done_cnt++;
            a_done_at = a_tcount;
            chk("ld_done_expected", 128'(sb_q.size() != 0), 128'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("load_tky", a_tky, e);
                chk("busy_after_load", a_busy, 0);
            end
        end
    endtask

    task automatic a_load(input logic [31:0] w[4], input int gap_after, input int gap_len,
                          input bit do_start, output int lat);
        a_tcount  = 0;
        a_done_at = -1;
        if (do_start) begin
            a_ld_start = 1'b1;
            a_tick();
            a_ld_start = 1'b0;
            chk("load_busy", a_busy, 1);
            chk("load_ready", a_pdi_ready, 1);
        end
        for (int i = 0; i < 4; i++) begin
            a_pdi       = w[i];
            a_pdi_valid = 1'b1;
            m_tky       = {m_tky[95:0], w[i]};
            if (i == 3) sb_q.push_back(m_tky);
            a_tick();
            if (i + 1 == gap_after) begin
                a_pdi_valid = 1'b0;
                a_pdi       = 32'hDEADBEEF;
                repeat (gap_len) a_tick();
                chk("stall_hold_tky", a_tky, m_tky);
                chk("stall_busy", a_busy, 1);
            end
        end
        a_pdi_valid = 1'b0;
        a_tick();
        chk("ld_done_one_cycle", a_ld_done, 0);
        chk("idle_not_ready", a_pdi_ready, 0);
        lat = a_done_at;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[5];
        logic [31:0]  w1[4];
        logic [31:0]  w2[4];
        logic [15:0]  bw;
        logic [127:0] b_model;
        int           lat;

        a_rst = 1; a_pdi_valid = 0; a_ld_start = 0; a_enc = 0; a_revert = 0;
        a_pdi = '0; a_sk = '0; a_skr = '0;
        b_rst = 1; b_pdi_valid = 0; b_ld_start = 0; b_enc = 0; b_revert = 0;
        b_pdi = '0; b_sk = '0; b_skr = '0;
        a_done_cnt = 0; a_tcount = 0; a_done_at = -1;
        tick();
        tick();
        a_rst = 0; b_rst = 0;
        m_tky = '0;
        chk("rst_tky", a_tky, 0);
        chk("rst_pdi_ready", a_pdi_ready, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ld_done", a_ld_done, 0);
        chk("rst_b_tky", b_tky, 0);

        // Basic load, then the same load with a three-cycle valid gap.
        w1 = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        a_load(w1, 0, 0, 1'b1, lat);
        chk("basic_tky", a_tky, 128'h11111111_22222222_33333333_44444444);
        chk("basic_latency", lat, 5);
        a_load(w1, 2, 3, 1'b1, lat);
        chk("stall_tky", a_tky, 128'h11111111_22222222_33333333_44444444);
        chk("stall_latency", lat, 8);

        // IDLE update priority table.
        vecs[0] = '{"enc_and_revert", 1'b1, 1'b1, {4{32'hAAAAAAAA}}, {4{32'h55555555}},
                    REV ? {4{32'h55555555}} : {4{32'hAAAAAAAA}}};
        vecs[1] = '{"hold_no_enable", 1'b0, 1'b0, {4{32'hFFFFFFFF}}, {4{32'h0F0F0F0F}},
                    vecs[0].exp};
        vecs[2] = '{"enc_only", 1'b1, 1'b0, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                    {4{32'h0F0F0F0F}}, 128'h01234567_89ABCDEF_FEDCBA98_76543210};
        vecs[3] = '{"revert_only", 1'b0, 1'b1, {4{32'h12121212}}, {4{32'hCAFEF00D}},
                    REV ? {4{32'hCAFEF00D}} : vecs[2].exp};
        vecs[4] = '{"enc_again", 1'b1, 1'b0, {4{32'h5A5AA5A5}}, 128'h0, {4{32'h5A5AA5A5}}};
        for (int i = 0; i < 5; i++) begin
            a_enc = vecs[i].enc; a_revert = vecs[i].rev;
            a_sk  = vecs[i].sk;  a_skr    = vecs[i].skr;
            a_tick();
            chk(vecs[i].name, a_tky, vecs[i].exp);
            chk("upd_not_busy", a_busy, 0);
        end
        a_enc = 0; a_revert = 0;
        m_tky = vecs[4].exp;

        // Update coinciding with ld_start: update lands, LOAD follows.
        a_enc = 1; a_sk = {4{32'h77777777}}; a_ld_start = 1;
        a_tick();
        a_enc = 0; a_ld_start = 0;
        chk("start_with_enc_tky", a_tky, {4{32'h77777777}});
        chk("start_with_enc_busy", a_busy, 1);
        m_tky = {4{32'h77777777}};
        w2 = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};
        a_load(w2, 0, 0, 1'b0, lat);
        chk("start_with_enc_latency", lat, 4);
        chk("start_with_enc_final", a_tky, 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3);

        // Reset mid-load, with valid and enc still asserted.
        a_ld_start = 1;
        a_tick();
        a_ld_start = 0;
        a_pdi_valid = 1; a_pdi = 32'hAAAA0001;
        a_tick();
        a_pdi = 32'hAAAA0002;
        a_tick();
        a_rst = 1; a_enc = 1; a_sk = {4{32'h99999999}};
        a_tick();
        chk("abort_tky", a_tky, 0);
        chk("abort_ready", a_pdi_ready, 0);
        chk("abort_busy", a_busy, 0);
        chk("abort_ld_done", a_ld_done, 0);
        a_rst = 0; a_enc = 0; a_pdi_valid = 0;
        a_tick();
        chk("abort_no_ld_done", a_ld_done, 0);
        chk("abort_tky_after", a_tky, 0);
        m_tky = '0;
        a_load(w1, 0, 0, 1'b1, lat);
        chk("fresh_tky", a_tky, 128'h11111111_22222222_33333333_44444444);
        chk("fresh_latency", lat, 5);
        chk("ld_done_count", a_done_cnt, 4);
        chk("scoreboard_empty", sb_q.size(), 0);

        // 16x8 instance: enc held and ld_start re-asserted during LOAD.
        b_model = '0;
        b_ld_start = 1;
        tick();
        b_ld_start = 0;
        chk("b_busy", b_busy, 1);
        b_enc = 1; b_sk = '1;
        for (int i = 0; i < 8; i++) begin
            bw          = 16'(i + 1) * 16'h1111;
            b_pdi       = bw;
            b_pdi_valid = 1;
            b_ld_start  = (i == 3);
            b_model     = {b_model[111:0], bw};
            tick();
            if (i < 7) chk("b_no_early_done", b_ld_done, 0);
        end
        b_pdi_valid = 0; b_ld_start = 0;
        chk("b_ld_done", b_ld_done, 1);
        chk("b_tky_model", b_tky, b_model);
        chk("b_tky_order", b_tky, 128'h1111_2222_3333_4444_5555_6666_7777_8888);
        chk("b_idle", b_busy, 0);
        tick();
        chk("b_enc_in_idle", b_tky, '1);
        chk("b_done_cleared", b_ld_done, 0);
        b_enc = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tky_update_param.md
TKY_UPDATE_PARAM -- requirements
Module: tky_update_param

Interface
REQ-001 Parameter LANE_W, default 32, tweakey lane width in bits, legal values 8, 16, 32, 64.
REQ-002 Parameter NUM_LANES, default 4, number of lanes, 2..8; TKY_W = LANE_W*NUM_LANES.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 pdi  input  LANE_W  load word from the public data interface.
REQ-006 pdi_valid  input  1  pdi holds a valid load word.
REQ-007 pdi_ready  output  1  block accepts pdi this cycle.
REQ-008 ld_start  input  1  begin a NUM_LANES-word shift load.
REQ-009 enc  input  1  round-update enable; captures skinny_tky.
REQ-010 revert  input  1  restore from skinny_tky_revert.
REQ-011 skinny_tky  input  TKY_W  next-round tweakey from the cipher datapath.
REQ-012 skinny_tky_revert  input  TKY_W  inverse-schedule tweakey.
REQ-013 tky  output  TKY_W  registered tweakey state, lane 0 = bits [LANE_W-1:0].
REQ-014 ld_done  output  1  one-cycle pulse when the final load word is accepted.
REQ-015 busy  output  1  high while the FSM is in LOAD.

Function
REQ-016 FSM states IDLE and LOAD; IDLE -> LOAD on ld_start; LOAD -> IDLE in the cycle the NUM_LANES-th word is accepted.
REQ-017 pdi_ready is high only in LOAD; a word is accepted when pdi_valid and pdi_ready are both high.
REQ-018 On acceptance: lane 0 <= pdi, lane i <= lane i-1 for i = 1..NUM_LANES-1; after NUM_LANES accepts, the first word sits in lane NUM_LANES-1.
REQ-019 Word counter width clog2(NUM_LANES); cleared on entry to LOAD; increments per accept only; pdi_valid low stalls with state held.
REQ-020 ld_done is asserted in the cycle after the last accept, for exactly one cycle.
REQ-021 ld_start while in LOAD is ignored; the counter does not restart.
REQ-022 In IDLE, update priority: revert (tky <= skinny_tky_revert) over enc (tky <= skinny_tky) over hold.
REQ-023 In LOAD, enc and revert are ignored; only shift load modifies tky.
REQ-024 enc or revert in the same cycle as ld_start in IDLE: the update takes effect, and LOAD begins next cycle.
REQ-025 Latency: every tky change is visible one cycle after the causing edge; no combinational path from any input to tky.
REQ-026 Lanes with no change hold their value; each lane register has a single write-enable (clock-gate friendly).

Reset
REQ-027 On rst: tky = 0, FSM = IDLE, counter = 0, pdi_ready = 0, ld_done = 0, busy = 0.
REQ-028 rst during LOAD aborts the load; partially shifted lanes are cleared and no ld_done is issued.
REQ-029 rst takes priority over all other inputs in the same cycle.

Configuration
REQ-030 Macro TKY_UPDATE_REVERT_EN: when defined, revert and skinny_tky_revert are functional per REQ-022.
REQ-031 When TKY_UPDATE_REVERT_EN is undefined, the ports remain, revert is ignored, and no revert multiplexer is synthesised.

Structure
REQ-032 Package romulus_pkg holds the LANE_W/NUM_LANES defaults, the FSM state enum, and the TKY_W derivation function.
REQ-033 One sub-module, tky_lane_reg (one LANE_W lane: shift-in, update, revert, enable), instantiated NUM_LANES times by a generate loop.

Verification
REQ-034 Defaults; rst, then ld_start, then 4 accepts of pdi 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> tky = 0x11111111_22222222_33333333_44444444, one ld_done pulse, busy low.
REQ-035 Load with pdi_valid dropped for 3 cycles after word 2 -> counter and tky held; final tky identical to REQ-034; ld_done delayed by 3 cycles.
REQ-036 IDLE, enc=1 and revert=1 together, skinny_tky = all-A, revert = all-5 -> tky = all-5 with the macro defined; all-A without it.
REQ-037 rst asserted after the second accept -> next cycle tky = 0, pdi_ready = 0, no ld_done; a fresh load completes correctly.
REQ-038 LANE_W=16, NUM_LANES=8 -> 8 accepts fill 128 bits in order; enc during LOAD ignored; ld_start during LOAD ignored.
